// File: rtl/minhash_pkg.sv
// Shared types and constants for the MinHash sketcher: FSM encoding and the per-sketch-word seed table.
package minhash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam int MAX_HASHES = 8;

    localparam logic [31:0] SEEDS [0:MAX_HASHES-1] = '{
        32'hac718add, 32'h5bd1e995, 32'h9e3779b9, 32'h7f4a7c15,
        32'h85ebca6b, 32'hc2b2ae35, 32'h27d4eb2f, 32'h165667b1
    };

endpackage

// File: rtl/murmur_4bytes.sv
// Combinational MurmurHash3 (x86_32) of a single 4-byte key under a given seed.
module murmur_4bytes #(
    parameter int HASHER_DATA_BITS = 32
) (
    input  logic [HASHER_DATA_BITS-1:0] seed,
    input  logic [HASHER_DATA_BITS-1:0] kmer,
    output logic [HASHER_DATA_BITS-1:0] signature
);

    logic [31:0] k_mul1, k_rot, k_mul2;
    logic [31:0] h_mix, h_rot, h_step, h_len;
    logic [31:0] f1, f2, f3, f4, f5;

    // Key scramble, then one body round, then the fmix32 finaliser with len = 4.
    assign k_mul1 = kmer * 32'hcc9e2d51;
    assign k_rot  = {k_mul1[16:0], k_mul1[31:17]};
    assign k_mul2 = k_rot * 32'h1b873593;

    assign h_mix  = seed ^ k_mul2;
    assign h_rot  = {h_mix[18:0], h_mix[31:19]};
    assign h_step = h_rot * 32'd5 + 32'he6546b64;
    assign h_len  = h_step ^ 32'd4;

    assign f1 = h_len ^ {16'h0, h_len[31:16]};
    assign f2 = f1 * 32'h85ebca6b;
    assign f3 = f2 ^ {13'h0, f2[31:13]};
    assign f4 = f3 * 32'hc2b2ae35;
    assign f5 = f4 ^ {16'h0, f4[31:16]};

    assign signature = f5;

endmodule

// File: rtl/minhash_sketcher.sv
// MinHash sketcher: hashes each k-mer against NUM_HASHES seeds through one shared hasher,
// keeps per-seed minima, and streams the sketch out after the last k-mer of a set.
module minhash_sketcher
    import minhash_pkg::*;
#(
    parameter int HASHER_DATA_BITS = 32,
    parameter int NUM_HASHES       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        kmer_valid,
    output logic                        kmer_ready,
    input  logic [HASHER_DATA_BITS-1:0] kmer,
    input  logic                        kmer_last,
    output logic                        sketch_valid,
    input  logic                        sketch_ready,
    output logic [2:0]                  sketch_idx,
    output logic [HASHER_DATA_BITS-1:0] sketch_data,
    output logic                        sketch_last
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_HASHES - 1);

    state_t                      state_q, state_d;
    logic [2:0]                  idx_q;
    logic [HASHER_DATA_BITS-1:0] kmer_q;
    logic                        last_q;
    logic [HASHER_DATA_BITS-1:0] min_q [NUM_HASHES];
    logic [HASHER_DATA_BITS-1:0] sig;
    logic                        idx_at_last;

    assign idx_at_last = (idx_q == LAST_IDX);

    murmur_4bytes #(
        .HASHER_DATA_BITS(HASHER_DATA_BITS)
    ) u_hash (
        .seed      (SEEDS[idx_q]),
        .kmer      (kmer_q),
        .signature (sig)
    );

    // Both ports: a word transfers on a rising edge where valid and ready are both high;
    // the producer holds valid and its payload stable until that edge.
    assign kmer_ready   = (state_q == IDLE) && !rst;
    assign sketch_valid = (state_q == DUMP);
    assign sketch_idx   = (state_q == DUMP) ? idx_q : 3'd0;
    assign sketch_data  = (state_q == DUMP) ? min_q[idx_q] : '0;
    assign sketch_last  = (state_q == DUMP) && idx_at_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (kmer_valid) state_d = HASH;
            HASH: if (idx_at_last) state_d = last_q ? DUMP : IDLE;
            DUMP: if (sketch_ready && idx_at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            kmer_q  <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < NUM_HASHES; i++) min_q[i] <= '1;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (kmer_valid) begin
                        kmer_q <= kmer;
                        last_q <= kmer_last;
                        idx_q  <= 3'd0;
                    end
                end
                HASH: begin
                    if (sig < min_q[idx_q]) min_q[idx_q] <= sig;
                    idx_q <= idx_at_last ? 3'd0 : idx_q + 3'd1;
                end
                DUMP: begin
                    // Re-arm each slot as it leaves so the next set starts from all-ones.
                    if (sketch_ready) begin
                        min_q[idx_q] <= '1;
                        idx_q        <= idx_at_last ? 3'd0 : idx_q + 3'd1;
                    end
                end
                default: idx_q <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_minhash_sketcher.sv
// Directed-plus-random bench for minhash_sketcher against a MurmurHash3/MinHash reference model.
module tb_minhash_sketcher;

    localparam int W  = 32;
    localparam int NH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kmer_valid = 1'b0;
    logic          kmer_ready;
    logic [W-1:0]  kmer = '0;
    logic          kmer_last = 1'b0;
    logic          sketch_valid;
    logic          sketch_ready = 1'b0;
    logic [2:0]    sketch_idx;
    logic [W-1:0]  sketch_data;
    logic          sketch_last;
    logic [W-1:0]  ref_sig;

    int checks = 0;
    int failures = 0;
    int accept_cnt = 0;
    int offer_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_set[$];
    logic [31:0]  model_seeds [0:NH-1] = '{
        32'hac718add, 32'h5bd1e995, 32'h9e3779b9, 32'h7f4a7c15,
        32'h85ebca6b, 32'hc2b2ae35, 32'h27d4eb2f, 32'h165667b1
    };

    always #5 clk = ~clk;

    minhash_sketcher #(
        .HASHER_DATA_BITS(W),
        .NUM_HASHES(NH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kmer_valid   (kmer_valid),
        .kmer_ready   (kmer_ready),
        .kmer         (kmer),
        .kmer_last    (kmer_last),
        .sketch_valid (sketch_valid),
        .sketch_ready (sketch_ready),
        .sketch_idx   (sketch_idx),
        .sketch_data  (sketch_data),
        .sketch_last  (sketch_last)
    );

    murmur_4bytes #(.HASHER_DATA_BITS(W)) u_ref_hash (
        .seed      (32'hac718add),
        .kmer      (32'hab1020c5),
        .signature (ref_sig)
    );

    always @(posedge clk) if (!rst && kmer_valid && kmer_ready) accept_cnt++;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic logic [31:0] murmur_model(input logic [31:0] seed, input logic [31:0] key);
        logic [31:0] k, h;
        k = key * 32'hcc9e2d51;
        k = rotl(k, 15);
        k = k * 32'h1b873593;
        h = seed ^ k;
        h = rotl(h, 13);
        h = h * 5 + 32'he6546b64;
        h = h ^ 32'd4;
        h = h ^ (h >> 16);
        h = h * 32'h85ebca6b;
        h = h ^ (h >> 13);
        h = h * 32'hc2b2ae35;
        h = h ^ (h >> 16);
        return h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic close_set();
        logic [31:0] m;
        for (int s = 0; s < NH; s++) begin
            m = 32'hffffffff;
            foreach (cur_set[j]) begin
                if (murmur_model(model_seeds[s], cur_set[j]) < m) m = murmur_model(model_seeds[s], cur_set[j]);
            end
            exp_q.push_back(m);
        end
        cur_set.delete();
    endtask

    // gap_mode 0: return right after accept; 1: also check busy/first-word latency.
    task automatic send_kmer(input logic [31:0] k, input logic last, input int gap_mode);
        int n;
        offer_cnt++;
        kmer = k;
        kmer_last = last;
        kmer_valid = 1'b1;
        n = 0;
        while (!kmer_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!kmer_ready) check("accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        kmer_valid = 1'b0;
        cur_set.push_back(k);
        if (last) close_set();
        if (gap_mode == 1) begin
            if (!last) begin
                n = 0;
                while (!kmer_ready && n < 40) begin
                    n++;
                    @(negedge clk);
                end
                check("busy_cycles", 32'(n), 32'(NH));
            end else begin
                n = 0;
                while (!sketch_valid && n < 40) begin
                    check("ready_low_in_hash", 32'(kmer_ready), 32'd0);
                    n++;
                    @(negedge clk);
                end
                check("first_word_latency", 32'(n), 32'(NH));
            end
        end
    endtask

    task automatic collect_sketch(input int stall_at, input int stall_len);
        int n;
        logic [31:0] e;
        for (int i = 0; i < NH; i++) begin
            n = 0;
            while (!sketch_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("sk_valid", 32'(sketch_valid), 32'd1);
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            check("sk_idx", 32'(sketch_idx), 32'(i));
            check("sk_data", sketch_data, e);
            check("sk_last", 32'(sketch_last), 32'(i == NH - 1));
            if (i == stall_at) begin
                sketch_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_idx", 32'(sketch_idx), 32'(i));
                    check("stall_data", sketch_data, e);
                    check("stall_kready", 32'(kmer_ready), 32'd0);
                end
            end
            if (i < NH - 1 && i != stall_at) check("dump_kready", 32'(kmer_ready), 32'd0);
            sketch_ready = 1'b1;
            @(negedge clk);
        end
        sketch_ready = 1'b0;
        check("post_dump_valid", 32'(sketch_valid), 32'd0);
        check("post_dump_kready", 32'(kmer_ready), 32'd1);
    endtask

    initial begin
        int n;
        // Reset behaviour
        repeat (2) @(negedge clk);
        check("rst_kready", 32'(kmer_ready), 32'd0);
        check("rst_svalid", 32'(sketch_valid), 32'd0);
        check("rst_sidx", 32'(sketch_idx), 32'd0);
        check("rst_sdata", sketch_data, 32'd0);
        check("rst_slast", 32'(sketch_last), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("kready_after_rst", 32'(kmer_ready), 32'd1);
        check("ref_hasher", ref_sig, murmur_model(32'hac718add, 32'hab1020c5));

        // Single-k-mer set
        send_kmer(32'hab1020c5, 1'b1, 1);
        check("word0_vs_ref", sketch_data, murmur_model(32'hac718add, 32'hab1020c5));
        collect_sketch(-1, 0);

        // Four random k-mers in one set
        for (int i = 0; i < 4; i++) send_kmer($urandom, i == 3, 1);
        collect_sketch(-1, 0);

        // Two back-to-back sets
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) send_kmer($urandom, i == 2, 1);
            collect_sketch(-1, 0);
        end

        // Back-pressure at idx 3
        send_kmer($urandom, 1'b0, 1);
        send_kmer($urandom, 1'b1, 1);
        collect_sketch(3, 5);

        // Offers held while busy
        send_kmer($urandom, 1'b0, 0);
        send_kmer($urandom, 1'b0, 0);
        send_kmer($urandom, 1'b1, 0);
        collect_sketch(-1, 0);

        // Reset during the 3rd HASH cycle of a last k-mer
        send_kmer($urandom, 1'b1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_kready", 32'(kmer_ready), 32'd0);
        check("midrst_svalid", 32'(sketch_valid), 32'd0);
        check("midrst_sidx", 32'(sketch_idx), 32'd0);
        check("midrst_sdata", sketch_data, 32'd0);
        check("midrst_slast", 32'(sketch_last), 32'd0);
        exp_q.delete();
        cur_set.delete();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (sketch_valid) n++;
        end
        check("no_sketch_after_rst", 32'(n), 32'd0);
        check("kready_after_midrst", 32'(kmer_ready), 32'd1);
        send_kmer($urandom_range(32'hffff, 0), 1'b1, 1);
        collect_sketch(-1, 0);

        check("accept_eq_offer", 32'(accept_cnt), 32'(offer_cnt));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
